// File: rtl/alu_exec_stage.sv
// ALU execute stage with a 2-entry skid buffer on the result path.
// Results are computed at accept time and held in order until consumed.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int EW = WIDTH + 3;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_zero;
  logic [EW-1:0]    w_entry;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_count;
  logic [EW-1:0]    r_e0;
  logic [EW-1:0]    r_e1;

  assign w_sum  = srca + srcb;
  assign w_diff = srca - srcb;

  assign w_add_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != srca[WIDTH-1]);
  assign w_sub_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != srca[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (alucontrol)
      OP_AND: w_res = srca & srcb;
      OP_OR:  w_res = srca | srcb;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = w_sub_ovf;
      end
      // sign XOR overflow keeps the compare correct when A-B wraps
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
      default: w_ill = 1'b1;
    endcase
  end

  assign w_zero  = (w_res == '0);
  assign w_entry = {w_ill, w_ovf, w_zero, w_res};

  assign in_ready  = (r_count != S_FULL);
  assign out_valid = (r_count != S_EMPTY);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= S_EMPTY;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      case (r_count)
        S_EMPTY: begin
          if (w_push) begin
            r_e0    <= w_entry;
            r_count <= S_ONE;
          end
        end
        S_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_e1    <= w_entry;
              r_count <= S_FULL;
            end
            2'b01: begin
              r_e0    <= '0;
              r_count <= S_EMPTY;
            end
            2'b11: r_e0 <= w_entry;
            default: ;
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            r_e0    <= r_e1;
            r_e1    <= '0;
            r_count <= S_ONE;
          end
        end
        default: r_count <= S_EMPTY;
      endcase
    end
  end

  assign {illegal, overflow, zero, aluresult} = out_valid ? r_e0 : '0;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases then random traffic
// compared against a queue-based arithmetic reference.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluresult;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        ill;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alucontrol(alucontrol),
    .srca(srca),
    .srcb(srcb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aluresult(aluresult),
    .zero(zero),
    .overflow(overflow),
    .illegal(illegal)
  );

  function automatic ent_t ref_alu(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    ent_t e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    r = 0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        r = sa + sb;
        e.res = r[31:0];
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        r = sa - sb;
        e.res = r[31:0];
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".result"}, aluresult, h.res);
    chk({tag, ".flags"}, {29'd0, zero, overflow, illegal},
        {29'd0, h.z, h.o, h.ill});
  endtask

  // drive after negedge, update model at posedge, check at next negedge
  task automatic cycle(input logic rst, input logic iv,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy,
                       input string tag);
    logic acc;
    logic pop;
    reset = rst;
    in_valid = iv;
    alucontrol = op;
    srca = a;
    srcb = b;
    out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      acc = iv && (q.size() != 2);
      pop = ordy && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_alu(op, a, b));
    end
    @(negedge clk);
    chk_model(tag);
  endtask

  function automatic logic [31:0] rand_op_val();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    alucontrol = 3'b000;
    srca = '0;
    srcb = '0;
    out_ready = 1'b0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, "reset0");
    cycle(1, 1, 3'b010, 32'h1, 32'h1, 1, "reset1");
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);

    cycle(0, 1, 3'b010, 32'h7FFF_FFFF, 32'h1, 1, "add_ovf");
    chk("add_ovf.res", aluresult, 32'h8000_0000);
    chk("add_ovf.flags", {29'd0, zero, overflow, illegal}, 32'b010);

    cycle(0, 1, 3'b110, 32'd5, 32'd5, 1, "sub_zero");
    chk("sub_zero.res", aluresult, 32'd0);
    chk("sub_zero.z", 32'(zero), 32'd1);
    cycle(0, 1, 3'b111, 32'h8000_0000, 32'h1, 1, "slt");
    chk("slt.res", aluresult, 32'd1);
    chk("slt.ovf", 32'(overflow), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, "drain0");

    cycle(0, 1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, "bp_and");
    cycle(0, 1, 3'b001, 32'h1, 32'h2, 0, "bp_or");
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    cycle(0, 1, 3'b010, 32'h9, 32'h9, 0, "bp_ignored");
    chk("bp.head", aluresult, 32'hF000_F000);
    cycle(0, 0, 0, 0, 0, 1, "bp_pop1");
    chk("bp.second", aluresult, 32'h0000_0003);
    cycle(0, 0, 0, 0, 0, 1, "bp_pop2");

    cycle(0, 1, 3'b100, 32'h1234_5678, 32'h1, 1, "illegal");
    chk("illegal.res", aluresult, 32'd0);
    chk("illegal.flags", {29'd0, zero, overflow, illegal}, 32'b101);
    cycle(0, 0, 0, 0, 0, 1, "drain1");

    cycle(0, 1, 3'b010, 32'd10, 32'd20, 0, "full_a");
    cycle(0, 1, 3'b010, 32'd30, 32'd40, 0, "full_b");
    cycle(1, 0, 0, 0, 0, 0, "full_rst");
    chk("full_rst.valid", 32'(out_valid), 32'd0);
    chk("full_rst.ready", 32'(in_ready), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, "post_rst");

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), rand_op_val(), rand_op_val(),
            ($urandom_range(0, 2) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
